fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage sitting directly upstream of decode/execute in the WISC core. Owns the architectural PC. Issues one read at a time to a variable-latency instruction memory and holds each returned word in a one-entry output buffer with a valid/stall handshake to decode. Handles branch redirects, including squashing an in-flight fetch, and stops fetching once a HLT word is captured; decode then consumes it to raise `hlt`.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset (byte address, word-aligned)
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- mem_addr  out  16  fetch address; equals internal PC
- mem_req  out  1  one-cycle read request; memory samples mem_addr on this edge
- mem_data  in  16  returned instruction word
- mem_valid  in  1  mem_data valid this cycle; ≥1 cycle after mem_req; ignored outside WAIT
- redirect  in  1  branch taken; load redirect_pc this edge
- redirect_pc  in  16  branch target
- stall  in  1  decode cannot accept the buffered instruction this cycle
- instr  out  16  buffered instruction word
- instr_pc  out  16  address of instr
- instr_pc2  out  16  instr_pc + 2 (for B/PCS), modulo 2^16
- instr_valid  out  1  buffer holds a live instruction
- hlt  out  1  sticky; set after HLT (opcode 4'hF) is consumed

## Operation
- States: REQ, WAIT, HALTED. Registers: pc, squash, output buffer (instr, instr_pc, instr_pc2, instr_valid), hlt.
- Consume = instr_valid & ~stall & ~redirect. The buffer is cleared on consume unless it refills the same edge.
- mem_req = rst_n & ~hlt & (state==REQ) & ~redirect & (~instr_valid | ~stall). At most one request is outstanding. A request is issued only when the buffer is empty or being consumed, so returned data always has room.
- REQ with mem_req high → WAIT. REQ with mem_req low → stay in REQ.
- WAIT, mem_valid, squash=0: capture mem_data into instr, instr_pc=pc, instr_pc2=pc+2, instr_valid=1, pc←pc+2. If mem_data[15:12]==4'hF → HALTED; else → REQ.
- WAIT, mem_valid, squash=1: drop data, squash←0, go to REQ.
- Redirect (any state, hlt=0): pc←redirect_pc, instr_valid←0.
  - In WAIT: squash←1 if mem_valid is low. If mem_valid is high the same cycle, the data is dropped and the next state is REQ.
  - In HALTED: go to REQ.
  - Redirect wins over stall and over capture.
- HALTED: no requests. Buffer holds HLT until consumed.
- hlt←1 on consume with instr[15:12]==4'hF. Once hlt=1: instr_valid←0, no requests, redirect and mem_valid ignored, until reset.
- PC arithmetic is 16-bit and wraps: 16'hFFFE+2 = 16'h0000.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - pc=RESET_PC, state=REQ, squash=0
  - instr=16'h0000, instr_pc=16'h0000, instr_pc2=16'h0000, instr_valid=0, hlt=0
  - mem_req=0
- First cycle after rst_n rises: mem_req=1, mem_addr=RESET_PC.
- Memory latency L≥1 cycles: request in cycle 0, mem_valid in cycle L, instr_valid=1 in cycle L+1, next mem_req in cycle L+1.
- Throughput with no stall: one instruction per L+1 cycles.
- Redirect in cycle t: mem_addr=redirect_pc in cycle t+1. mem_req in t+1 if state is REQ; otherwise after the squashed return.
- hlt rises the cycle after HLT is consumed.
- Reset mid-WAIT: in-flight data is abandoned; fetch restarts at RESET_PC.

## Test plan
- Sequential fetch, L=1, memory {0:16'h1123, 2:16'h2456, 4:16'hF000}, stall=0 → instr_pc 0,2,4 in cycles 2,4,6; instr_pc2 2,4,6; hlt=1 in cycle 7; no mem_req after the HLT capture.
- Stall: L=2, stall held 5 cycles after first instr_valid → instr stays 16'h1123, instr_valid stays 1, no second mem_req until the stall drops; the next request is at addr 2.
- Redirect during WAIT: L=3, redirect=1 with redirect_pc=16'h0040 one cycle after the request to 2 → the returned word is dropped, the next mem_addr is 16'h0040, instr_valid stays 0 until the 0x40 data arrives.
- Redirect coincident with mem_valid, and redirect while a HLT is buffered → data/HLT flushed, hlt stays 0, fetch resumes at redirect_pc.
- Wrap: RESET_PC=16'hFFFE, word 16'h1000 → instr_pc2=16'h0000, next mem_addr=16'h0000.
- Async reset asserted mid-WAIT with hlt=1 → all outputs return to reset values immediately, without waiting for a clock edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read at a time to a
// variable-latency instruction memory and buffers the returned word for decode.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic [15:0] mem_data,
  input  logic        mem_valid,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic [15:0] instr_pc2,
  output logic        instr_valid,
  output logic        hlt
);

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } fetchState_t;

  fetchState_t state, stateNext;

  logic [15:0] pc, pcNext, pcPlus2;
  logic        squash, squashNext;
  logic [15:0] instrNext, instrPcNext, instrPc2Next;
  logic        instrValidNext, hltNext;
  logic        consume, dataIsHlt, bufIsHlt;

  assign pcPlus2   = pc + 16'd2;
  assign dataIsHlt = (mem_data[15:12] == 4'hF);
  assign bufIsHlt  = (instr[15:12] == 4'hF);
  assign consume   = instr_valid & ~stall & ~redirect;

  assign mem_addr = pc;
  // A request only goes out when the buffer is empty or draining this edge,
  // so a returning word always has somewhere to land.
  assign mem_req  = rst_n & ~hlt & (state == REQ) & ~redirect & (~instr_valid | ~stall);

  // Next-state, PC, squash and output-buffer update.
  always_comb begin
    stateNext      = state;
    pcNext         = pc;
    squashNext     = squash;
    instrNext      = instr;
    instrPcNext    = instr_pc;
    instrPc2Next   = instr_pc2;
    instrValidNext = instr_valid;
    hltNext        = hlt;

    if (hlt) begin
      instrValidNext = 1'b0;
    end else begin
      if (consume) begin
        instrValidNext = 1'b0;
        if (bufIsHlt) begin
          hltNext = 1'b1;
        end
      end

      if (redirect) begin
        // Redirect overrides capture and stall; a fetch still in flight is
        // marked for squashing unless its data is returning right now.
        pcNext         = redirect_pc;
        instrValidNext = 1'b0;
        case (state)
          WAIT: begin
            if (mem_valid) begin
              squashNext = 1'b0;
              stateNext  = REQ;
            end else begin
              squashNext = 1'b1;
            end
          end
          HALTED:  stateNext = REQ;
          default: stateNext = REQ;
        endcase
      end else begin
        case (state)
          REQ: begin
            if (mem_req) begin
              stateNext = WAIT;
            end
          end
          WAIT: begin
            if (mem_valid) begin
              if (squash) begin
                squashNext = 1'b0;
                stateNext  = REQ;
              end else begin
                instrNext      = mem_data;
                instrPcNext    = pc;
                instrPc2Next   = pcPlus2;
                instrValidNext = 1'b1;
                pcNext         = pcPlus2;
                stateNext      = dataIsHlt ? HALTED : REQ;
              end
            end
          end
          HALTED:  stateNext = HALTED;
          default: stateNext = REQ;
        endcase
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= REQ;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_pc2   <= '0;
      instr_valid <= 1'b0;
      hlt         <= 1'b0;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      squash      <= squashNext;
      instr       <= instrNext;
      instr_pc    <= instrPcNext;
      instr_pc2   <= instrPc2Next;
      instr_valid <= instrValidNext;
      hlt         <= hltNext;
    end
  end

endmodule
